and_gate_8b: RTL and testbench
==============================

Name: and_gate_8b

Overview:
- Registered 8-bit bitwise AND unit for the 8-bit CPU gate library (8BitGate).
- Accepts two operands with a valid strobe and returns A AND B one clock later, together with zero and all-ones status flags.
- The datapath/ALU consumes these flags for logic-instruction condition codes.

Parameters:
- WIDTH, 8, operand/result width in bits; all widths below scale with it, and tests use 8.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operands on input_a/input_b are valid this cycle
- input_a  input  WIDTH  operand A
- input_b  input  WIDTH  operand B
- output_z  output  WIDTH  registered result A AND B
- out_valid  output  1  output_z and flags were updated by the last edge
- zero_flag  output  1  registered: result equals all zeros
- ones_flag  output  1  registered: result equals all ones
- popcount  output  $clog2(WIDTH)+1  registered number of 1 bits in the result (only with AND_GATE_8B_POPCNT_EN)

Behaviour:
- Reset:
  - The rst assertion acts immediately, without waiting for clk.
  - Reset values: output_z=0, out_valid=0, zero_flag=1, ones_flag=0, popcount=0.
  - While rst is high, all outputs hold these values regardless of inputs.
  - Release takes effect at the first rising clk with rst low.
- Capture, on a rising clk edge with in_valid=1:
  - output_z <= input_a & input_b, computed bit by bit with no carries and no cross-bit interaction.
  - zero_flag <= (result == 0).
  - ones_flag <= (result == all ones).
  - out_valid <= 1.
- Hold, on a rising clk edge with in_valid=0:
  - out_valid <= 0.
  - output_z, zero_flag, ones_flag and popcount keep their previous values.
- Latency: exactly 1 cycle from the in_valid edge to out_valid/result.
  - Throughput is 1 operation per cycle.
  - Back-to-back in_valid produces back-to-back out_valid with no bubbles.
- No backpressure: the consumer must sample when out_valid=1, because a new operation overwrites the result on the next valid edge.
- Flags always describe the current output_z value; they are never stale relative to it.
- Inputs are sampled only at the edge. Changes on input_a/input_b between edges, or while in_valid=0, have no effect.
- X or Z values on the inputs while in_valid=0 must not propagate to the outputs.
- Reset mid-stream: an in_valid operation coincident with rst asserted is discarded. The first post-reset result appears 1 cycle after the first in_valid edge with rst low.
- No internal state beyond the output registers; no FSM.

Optional Feature:
- Macro: AND_GATE_8B_POPCNT_EN
- Defined:
  - The popcount port exists and is registered alongside output_z.
  - It is updated on the same valid edge and reset to 0.
  - Range is 0..WIDTH.
- Not defined:
  - The popcount port and its logic are absent.
  - All other ports and timing are identical.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> outputs go to output_z=00, out_valid=0, zero_flag=1, ones_flag=0 immediately, without a clk edge.
- A=00, B=00 with in_valid=1 -> next cycle: output_z=00, zero_flag=1, ones_flag=0, out_valid=1, popcount=0.
- A=FF, B=FF -> output_z=FF, zero_flag=0, ones_flag=1, popcount=8.
- A=0F, B=F0 -> output_z=00, zero_flag=1, ones_flag=0. Confirms disjoint masks clear the result.
- A=3C, B=66 -> output_z=24, zero_flag=0, ones_flag=0, popcount=2. Then drop in_valid and change the inputs to FF/FF -> out_valid=0 and output_z stays 24.
- Back-to-back stream FF/FF, 3C/66, 0F/F0 on consecutive cycles -> results FF, 24, 00 on consecutive cycles with out_valid held high. Assert rst during the second input cycle -> that operation is discarded and outputs return to reset values.

Source files
------------

// File: rtl/and_gate_8b.sv
// -----------------------------------------------------------------------------
// and_gate_8b
//
// Registered WIDTH-bit bitwise AND unit for the 8-bit CPU gate library.
// Two operands are captured on a rising clk edge with in_valid high; the
// result A & B appears one cycle later together with zero / all-ones status
// flags used by the ALU for logic-instruction condition codes.
//
// Optional feature (compile-time macro AND_GATE_8B_POPCNT_EN):
//   When defined, a registered popcount of the result is also produced.
//   When undefined, the popcount port and its logic are absent.
//
// Ports:
//   clk        in   1                 system clock, rising-edge active
//   rst        in   1                 asynchronous reset, active-high
//   in_valid   in   1                 operands valid this cycle
//   input_a    in   WIDTH             operand A
//   input_b    in   WIDTH             operand B
//   output_z   out  WIDTH             registered A & B
//   out_valid  out  1                 result/flags updated by the last edge
//   zero_flag  out  1                 registered: result is all zeros
//   ones_flag  out  1                 registered: result is all ones
//   popcount   out  $clog2(WIDTH)+1   registered count of 1 bits
//                                     (only with AND_GATE_8B_POPCNT_EN)
//
// Handshake: single-cycle valid strobe, no backpressure. An operation is
// accepted on every rising edge where in_valid=1 (and rst=0). out_valid is
// high for exactly the cycle following each accepted operation; the consumer
// must sample then, since the next accepted operation overwrites the result.
// -----------------------------------------------------------------------------
module and_gate_8b #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         input_a,
    input  logic [WIDTH-1:0]         input_b,
    output logic [WIDTH-1:0]         output_z,
    output logic                     out_valid,
    output logic                     zero_flag,
`ifdef AND_GATE_8B_POPCNT_EN
    output logic                     ones_flag,
    output logic [$clog2(WIDTH):0]   popcount
`else
    output logic                     ones_flag
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Combinational next-value datapath
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             w_ones;

    always_comb begin
        w_result = input_a & input_b;
        w_zero   = ~|w_result;
        w_ones   = &w_result;
    end

    // Output registers
    logic [WIDTH-1:0] r_z;
    logic             r_valid;
    logic             r_zero;
    logic             r_ones;

    // Registers only load when in_valid is high, so X/Z on the operands
    // while idle never reaches the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z     <= '0;
            r_valid <= 1'b0;
            r_zero  <= 1'b1;   // reset result is zero, flag agrees with it
            r_ones  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_z    <= w_result;
                r_zero <= w_zero;
                r_ones <= w_ones;
            end
        end
    end

    assign output_z  = r_z;
    assign out_valid = r_valid;
    assign zero_flag = r_zero;
    assign ones_flag = r_ones;

`ifdef AND_GATE_8B_POPCNT_EN
    function automatic logic [CW-1:0] count_ones(input logic [WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{(CW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [CW-1:0] w_popcount;
    logic [CW-1:0] r_popcount;

    always_comb begin
        w_popcount = count_ones(w_result);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_popcount <= '0;
        end else if (in_valid) begin
            r_popcount <= w_popcount;
        end
    end

    assign popcount = r_popcount;
`endif

endmodule

// File: tb/tb_and_gate_8b.sv
module tb_and_gate_8b;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic [WIDTH-1:0] output_z;
    logic             out_valid;
    logic             zero_flag;
    logic             ones_flag;
`ifdef AND_GATE_8B_POPCNT_EN
    logic [$clog2(WIDTH):0] popcount;
`endif

    int checks = 0;
    int errors = 0;

    and_gate_8b #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .input_a   (input_a),
        .input_b   (input_b),
        .output_z  (output_z),
        .out_valid (out_valid),
        .zero_flag (zero_flag),
`ifdef AND_GATE_8B_POPCNT_EN
        .ones_flag (ones_flag),
        .popcount  (popcount)
`else
        .ones_flag (ones_flag)
`endif
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all outputs; pop is ignored when the popcount port is absent.
    task automatic check_all(input string tag, input logic [7:0] z, input logic v,
                             input logic zf, input logic of, input logic [3:0] pop);
        check({tag, ".z"},    {24'd0, output_z}, {24'd0, z});
        check({tag, ".vld"},  {31'd0, out_valid}, {31'd0, v});
        check({tag, ".zero"}, {31'd0, zero_flag}, {31'd0, zf});
        check({tag, ".ones"}, {31'd0, ones_flag}, {31'd0, of});
`ifdef AND_GATE_8B_POPCNT_EN
        check({tag, ".pop"},  {28'd0, popcount}, {28'd0, pop});
`else
        if (pop > 4'd8) $display("note: bad pop arg in %s", tag);
`endif
    endtask

    // Drive at negedge, return 1 time unit after the following posedge.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid = v;
        input_a  = a;
        input_b  = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;       // ignored while in reset
        input_a  = 8'hFF;
        input_b  = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);

        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        input_a  = 'x;
        input_b  = 'x;
        @(posedge clk);
        #1;
        check_all("idle_x_inputs", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);

        step(1'b1, 8'h00, 8'h00);
        check_all("and_00_00", 8'h00, 1'b1, 1'b1, 1'b0, 4'd0);

        step(1'b1, 8'hFF, 8'hFF);
        check_all("and_ff_ff", 8'hFF, 1'b1, 1'b0, 1'b1, 4'd8);

        step(1'b1, 8'h0F, 8'hF0);
        check_all("and_0f_f0", 8'h00, 1'b1, 1'b1, 1'b0, 4'd0);

        step(1'b1, 8'h3C, 8'h66);
        check_all("and_3c_66", 8'h24, 1'b1, 1'b0, 1'b0, 4'd2);

        step(1'b0, 8'hFF, 8'hFF);
        check_all("hold_ff", 8'h24, 1'b0, 1'b0, 1'b0, 4'd2);

        step(1'b0, 'x, 'x);
        check_all("hold_x", 8'h24, 1'b0, 1'b0, 1'b0, 4'd2);

        // Back-to-back stream
        step(1'b1, 8'hFF, 8'hFF);
        check_all("b2b_0", 8'hFF, 1'b1, 1'b0, 1'b1, 4'd8);
        step(1'b1, 8'h3C, 8'h66);
        check_all("b2b_1", 8'h24, 1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b1, 8'h0F, 8'hF0);
        check_all("b2b_2", 8'h00, 1'b1, 1'b1, 1'b0, 4'd0);

        // Asynchronous reset mid-cycle, no clock edge in between
        step(1'b1, 8'hA5, 8'hF0);
        check_all("pre_async", 8'hA0, 1'b1, 1'b0, 1'b0, 4'd2);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);

        // Reset during the second operation of a stream
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'hFF, 8'hFF);
        check_all("rs_first", 8'hFF, 1'b1, 1'b0, 1'b1, 4'd8);
        @(negedge clk);
        in_valid = 1'b1;
        input_a  = 8'h3C;
        input_b  = 8'h66;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check_all("rs_discard", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("rs_release", 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b1, 8'h0F, 8'h0E);
        check_all("rs_post", 8'h0E, 1'b1, 1'b0, 1'b0, 4'd3);
        step(1'b0, 8'h00, 8'h00);
        check_all("rs_idle", 8'h0E, 1'b0, 1'b0, 1'b0, 4'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
